// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame-buffer arbiter.
package fb_pkg;

    typedef enum logic [1:0] {
        S_FILL0 = 2'd0,
        S_RUN   = 2'd1,
        S_PEND  = 2'd2
    } fb_state_t;

    localparam int PIXEL_ROW    = 60;
    localparam int PIXEL_COLUMN = 80;
    localparam int FRAME_WORDS  = PIXEL_ROW * PIXEL_COLUMN;

    localparam logic [19:0] BANK0_BASE = 20'h00000;
    localparam logic [19:0] BANK1_BASE = 20'h02000;

endpackage

// File: rtl/fb_sram_mux.sv
// Combinational SRAM port steering: a granted producer beat owns the port,
// otherwise the display read of the front bank does.
module fb_sram_mux
    import fb_pkg::*;
#(
    parameter int                ADDR_W  = 20,
    parameter int                DATA_W  = 16,
    parameter logic [ADDR_W-1:0] B1_BASE = ADDR_W'(BANK1_BASE)
) (
    input  logic              front_bank,
    input  logic              back_bank,
    input  logic              wr_beat,
    input  logic              wr_in_range,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we
);

    logic [ADDR_W-1:0] front_base;
    logic [ADDR_W-1:0] back_base;

    always_comb begin
        front_base = front_bank ? B1_BASE : ADDR_W'(BANK0_BASE);
        back_base  = back_bank  ? B1_BASE : ADDR_W'(BANK0_BASE);
        sram_wdata = wr_data;
        sram_we    = 1'b0;
        sram_addr  = front_base + vga_addr;
        if (wr_beat) begin
            // out-of-range beats are consumed but never reach the array
            sram_we   = wr_in_range;
            sram_addr = back_base + wr_addr;
        end
    end

endmodule

// File: rtl/fb_bank_arbiter.sv
// Double-buffered frame-buffer arbiter: display reads the front bank, producer
// fills the back bank, swap at frame boundary. FB_STALL_CNT_EN adds a stall counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_FILL0 | first frame being written into bank 0, display not started
//   S_RUN   | front bank displayed, producer filling the other bank
//   S_PEND  | back bank complete, waiting for frame_done to swap
module fb_bank_arbiter #(
    parameter int                ADDR_W      = 20,
    parameter int                DATA_W      = 16,
    parameter int                FRAME_WORDS = 4800,
    parameter logic [ADDR_W-1:0] BANK1_BASE  = 20'h02000
) (
    input  logic              i_clk_25M,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_vga_addr,
    input  logic              i_vga_active,
    input  logic              i_frame_done,
    output logic [DATA_W-1:0] o_vga_data,
    output logic              o_start_display,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_last,
    output logic              o_wr_ready,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_we,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_front_bank,
    output logic              o_addr_err,
    output logic [15:0]       o_stall_cnt
);

    localparam logic [ADDR_W-1:0] FRAME_LIMIT = ADDR_W'(FRAME_WORDS);

    fb_pkg::fb_state_t state, state_nxt;
    logic front_nxt;
    logic start_nxt;
    logic back_bank;
    logic wr_beat;
    logic wr_in_range;
    logic last_beat;

    assign o_wr_ready  = !i_vga_active && (state != fb_pkg::S_PEND);
    assign wr_beat     = i_wr_valid && o_wr_ready;
    assign wr_in_range = (i_wr_addr < FRAME_LIMIT);
    assign last_beat   = wr_beat && i_wr_last;
    assign back_bank   = (state == fb_pkg::S_FILL0) ? 1'b0 : !o_front_bank;
    assign o_vga_data  = i_sram_rdata;

    always_ff @(posedge i_clk_25M) begin
        if (i_rst) begin
            state           <= fb_pkg::S_FILL0;
            o_front_bank    <= 1'b0;
            o_start_display <= 1'b0;
            o_addr_err      <= 1'b0;
        end else begin
            state           <= state_nxt;
            o_front_bank    <= front_nxt;
            o_start_display <= start_nxt;
            o_addr_err      <= o_addr_err || (wr_beat && !wr_in_range);
        end
    end

    always_comb begin
        state_nxt = state;
        front_nxt = o_front_bank;
        start_nxt = o_start_display;
        case (state)
            fb_pkg::S_FILL0: begin
                if (last_beat) begin
                    state_nxt = fb_pkg::S_RUN;
                    start_nxt = 1'b1;
                end
            end
            fb_pkg::S_RUN: begin
                // a coincident frame_done is ignored; the swap waits for the next one
                if (last_beat) begin
                    state_nxt = fb_pkg::S_PEND;
                end
            end
            fb_pkg::S_PEND: begin
                if (i_frame_done) begin
                    state_nxt = fb_pkg::S_RUN;
                    front_nxt = !o_front_bank;
                end
            end
            default: begin
                state_nxt = fb_pkg::S_FILL0;
            end
        endcase
    end

`ifdef FB_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge i_clk_25M) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (i_wr_valid && !o_wr_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

    fb_sram_mux #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .B1_BASE (BANK1_BASE)
    ) u_sram_mux (
        .front_bank  (o_front_bank),
        .back_bank   (back_bank),
        .wr_beat     (wr_beat),
        .wr_in_range (wr_in_range),
        .vga_addr    (i_vga_addr),
        .wr_addr     (i_wr_addr),
        .wr_data     (i_wr_data),
        .sram_addr   (o_sram_addr),
        .sram_wdata  (o_sram_wdata),
        .sram_we     (o_sram_we)
    );

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// Randomized bench for fb_bank_arbiter against a bank-level reference model.
module tb_fb_bank_arbiter;

    localparam int          FW  = 4800;
    localparam logic [19:0] B1  = 20'h02000;
    localparam logic [15:0] PAT = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] vga_addr;
    logic        vga_active;
    logic        frame_done;
    logic [15:0] o_vga_data;
    logic        o_start_display;
    logic        wr_valid;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_last;
    logic        o_wr_ready;
    logic [19:0] o_sram_addr;
    logic [15:0] o_sram_wdata;
    logic        o_sram_we;
    logic [15:0] sram_rdata;
    logic        o_front_bank;
    logic        o_addr_err;
    logic [15:0] o_stall_cnt;

    always #20 clk = ~clk;

    // SRAM stand-in: read data is a fixed function of the address
    assign sram_rdata = o_sram_addr[15:0] ^ PAT;

    fb_bank_arbiter dut (
        .i_clk_25M       (clk),
        .i_rst           (rst),
        .i_vga_addr      (vga_addr),
        .i_vga_active    (vga_active),
        .i_frame_done    (frame_done),
        .o_vga_data      (o_vga_data),
        .o_start_display (o_start_display),
        .i_wr_valid      (wr_valid),
        .i_wr_addr       (wr_addr),
        .i_wr_data       (wr_data),
        .i_wr_last       (wr_last),
        .o_wr_ready      (o_wr_ready),
        .o_sram_addr     (o_sram_addr),
        .o_sram_wdata    (o_sram_wdata),
        .o_sram_we       (o_sram_we),
        .i_sram_rdata    (sram_rdata),
        .o_front_bank    (o_front_bank),
        .o_addr_err      (o_addr_err),
        .o_stall_cnt     (o_stall_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: which bank is shown, whether display started, whether back bank is full
    bit m_started;
    bit m_full;
    bit m_front;
    bit m_err;
    int m_stall;

    int p;
    int frames;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit model_ready();
        return !vga_active && !m_full;
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_full    = 0;
        m_front   = 0;
        m_err     = 0;
        m_stall   = 0;
    endtask

    // inputs are already applied; check combinational and registered outputs, then clock
    task automatic cycle(input bit do_chk);
        bit          rdy, beat, inr;
        logic [19:0] front_base, back_base, exp_addr;
        #1;
        front_base = m_front ? B1 : 20'h0;
        back_base  = !m_started ? 20'h0 : (m_front ? 20'h0 : B1);
        rdy        = model_ready();
        beat       = wr_valid && rdy;
        inr        = (int'(wr_addr) < FW);
        exp_addr   = beat ? back_base + wr_addr : front_base + vga_addr;
        if (do_chk && !rst) begin
            chk("wr_ready", o_wr_ready, rdy);
            chk("sram_we", o_sram_we, beat && inr);
            if (!beat || inr) begin
                chk("sram_addr", o_sram_addr, exp_addr);
                chk("vga_data", o_vga_data, exp_addr[15:0] ^ PAT);
            end
            if (beat && inr) chk("sram_wdata", o_sram_wdata, wr_data);
            chk("front_bank", o_front_bank, m_front);
            chk("start_display", o_start_display, m_started);
            chk("addr_err", o_addr_err, m_err);
            chk("stall_cnt", o_stall_cnt, m_stall);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (beat && wr_last) begin
                if (!m_started) m_started = 1;
                else m_full = 1;
            end else if (m_full && frame_done) begin
                m_front = !m_front;
                m_full  = 0;
            end
            if (beat && !inr) m_err = 1;
`ifdef FB_STALL_CNT_EN
            if (wr_valid && !rdy && m_stall < 65535) m_stall++;
`endif
        end
        #1;
    endtask

    task automatic drive(input bit act, input bit done, input bit valid,
                         input int addr, input int vaddr);
        vga_active = act;
        frame_done = done;
        wr_valid   = valid;
        wr_addr    = 20'(addr);
        wr_last    = (addr == FW - 1);
        wr_data    = 16'($urandom);
        vga_addr   = 20'(vaddr);
    endtask

    // one producer-side cycle; advances the frame pointer when the beat is taken
    task automatic prod_cycle(input bit act, input bit done, input bit valid);
        bit acc;
        drive(act, done, valid, p, $urandom_range(FW - 1, 0));
        acc = valid && !act && !m_full;
        cycle(1);
        if (acc) begin
            if (p == FW - 1) begin
                p = 0;
                frames++;
            end else begin
                p++;
            end
        end
    endtask

    initial begin
        bit want_coinc;
        bit act, done, valid;
        int budget;

        model_reset();
        p      = 0;
        frames = 0;
        rst    = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) cycle(0);
        rst = 1'b0;
        #1;
        chk("reset_front", o_front_bank, 0);
        chk("reset_start", o_start_display, 0);
        chk("reset_err", o_addr_err, 0);
        chk("reset_stall", o_stall_cnt, 0);
        chk("reset_we", o_sram_we, 0);

        // first frame into bank 0 with the display idle
        repeat (FW) prod_cycle(0, 0, 1);
        chk("start_after_fill", o_start_display, 1);
        chk("front_after_fill", o_front_bank, 0);

        // producer held off by the active read window
        repeat (10) prod_cycle(1, 0, 1);
`ifdef FB_STALL_CNT_EN
        chk("stall_after_10", o_stall_cnt, 10);
`else
        chk("stall_after_10", o_stall_cnt, 0);
`endif

        // random traffic, with one last beat forced onto a frame_done
        want_coinc = 1;
        budget     = 60000;
        while (frames < 5 && budget > 0) begin
            act   = ($urandom_range(99, 0) < 25);
            done  = ($urandom_range(299, 0) == 0);
            valid = ($urandom_range(99, 0) < 80);
            if (want_coinc && p == FW - 1 && m_started && !m_full) begin
                act        = 0;
                done       = 1;
                valid      = 1;
                want_coinc = 0;
            end
            prod_cycle(act, done, valid);
            budget--;
        end
        chk("random_phase_done", (frames >= 5), 1);
        chk("coincidence_hit", want_coinc, 0);

        // out-of-range beat, after a frame_done that frees the back bank if pending
        prod_cycle(0, 1, 0);
        drive(0, 0, 1, FW, 5);
        cycle(1);
        repeat (5) prod_cycle($urandom_range(1, 0) == 1, 0, 1);
        chk("addr_err_sticky", o_addr_err, 1);

        // reset in the middle of a frame
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) cycle(0);
        rst = 1'b0;
        p   = 0;
        #1;
        chk("rst2_front", o_front_bank, 0);
        chk("rst2_start", o_start_display, 0);
        chk("rst2_err", o_addr_err, 0);
        chk("rst2_stall", o_stall_cnt, 0);
        repeat (300) prod_cycle($urandom_range(99, 0) < 30, $urandom_range(9, 0) == 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
